bus_master_if: RTL and testbench
================================

Name: bus_master_if

Overview:
- Master-side endpoint of the shared system bus; it is the requesting party for the two-master bus arbiter.
- Accepts one single-beat access at a time from a CPU-side port (instruction fetch or data LSU).
- Raises the arbiter request and waits for grant, then drives the bus until the slave is ready or errors, or until a timeout.
- Returns read data and status to the CPU port as a one-cycle acknowledge pulse.
- Handles grant loss mid-access: a higher-priority master may take the bus at any clock edge, and the access is retried.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- TIMEOUT, 256, number of ACCESS cycles without bus_rdy/bus_err before the access completes with error; range 2..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  access request; sampled only in IDLE
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  byte address
- cpu_wdata  in  DW  write data
- cpu_be  in  DW/8  byte enables
- cpu_busy  out  1  high whenever state != IDLE
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid with cpu_ack
- cpu_err  out  1  error/timeout status, valid with cpu_ack
- bus_req  out  1  request to arbiter
- bus_grnt  in  1  grant from arbiter (may be high without request)
- bus_as  out  1  address strobe; bus owned and access active
- bus_addr  out  AW  address, zero when bus_as=0
- bus_we  out  1  write enable, zero when bus_as=0
- bus_wdata  out  DW  write data, zero when bus_as=0
- bus_be  out  DW/8  byte enables, zero when bus_as=0
- bus_rdata  in  DW  slave read data
- bus_rdy  in  1  slave ready/complete
- bus_err  in  1  slave error

Behaviour:
- States: IDLE, ARB, ACCESS, RESP.
- Reset: state=IDLE, timer=0, latched request registers=0, cpu_rdata=0, cpu_err=0. All outputs 0 after reset.
- Reset mid-operation: IDLE at the next edge, no cpu_ack issued, bus_req dropped.
- IDLE:
  - cpu_req=1 latches we/addr/wdata/be into internal registers and moves to ARB.
  - CPU inputs are ignored in every other state.
- ARB:
  - bus_req=1, timer cleared.
  - bus_grnt=1 -> ACCESS. The grant is evaluated in ARB even if it was already high when the request rose.
- ACCESS:
  - bus_req=1; bus_as = bus_grnt (combinational). Bus fields drive the latched values only while bus_as=1.
  - Events are evaluated in priority order, first match wins:
    1. bus_grnt=0 -> ARB (grant lost; retry; timer cleared; rdy/err ignored).
    2. bus_err=1 -> RESP with cpu_err=1, cpu_rdata=0.
    3. bus_rdy=1 -> RESP with cpu_rdata=bus_rdata (reads) or 0 (writes), cpu_err=0.
    4. timer==TIMEOUT-1 -> RESP with cpu_err=1, cpu_rdata=0.
    5. Otherwise timer+1 and stay in ACCESS.
- RESP:
  - cpu_ack=1 for exactly one cycle; bus_req=0, bus_as=0; -> IDLE.
  - cpu_rdata/cpu_err hold their values until the next RESP.
- Minimum latency with grant already held and slave zero-wait:
  - cycle0 IDLE accepts the request
  - cycle1 ARB
  - cycle2 ACCESS with rdy
  - cycle3 cpu_ack
  - Next request can be accepted in cycle4; cpu_busy is 0 in cycle4.
- Retry on grant loss is unbounded; the timeout applies per ACCESS attempt only.
- bus_req is registered/state-decoded: 1 in ARB and ACCESS only.
- All outputs except bus_as and the bus_* field muxes are registered or pure state decodes.

Test Plan:
- Zero-wait read:
  - Stimulus: bus_grnt held 1; cpu_req with addr=0x1000_0040; slave returns rdy with rdata=0xDEADBEEF in the first ACCESS cycle.
  - Required: bus_as high exactly 1 cycle with bus_addr=0x1000_0040, bus_we=0; cpu_ack 3 cycles after the request cycle; cpu_rdata=0xDEADBEEF; cpu_err=0.
- Write with wait states:
  - Stimulus: wdata=0x12345678, be=4'b0011; slave asserts rdy after 4 ACCESS cycles.
  - Required: bus_wdata/bus_be/bus_we=1 stable for all 4 cycles; single cpu_ack; cpu_rdata=0.
- Late grant:
  - Stimulus: bus_grnt=0 for 5 cycles after the request.
  - Required: stays in ARB with bus_req=1, bus_as=0, bus fields all zero; ACCESS starts the cycle after bus_grnt rises.
- Grant loss mid-access:
  - Stimulus: bus_grnt drops in the 2nd ACCESS cycle while bus_rdy=1 in that same cycle.
  - Required: no completion; return to ARB; access reissued after grant returns; exactly one cpu_ack in total.
- Timeout and error:
  - Stimulus: TIMEOUT=8 and slave never responds. Separately, the slave asserts bus_err together with bus_rdy.
  - Required: timeout case gives cpu_ack with cpu_err=1 after exactly 8 ACCESS cycles. Error case gives cpu_err=1 and cpu_rdata=0.
- Reset in ACCESS:
  - Stimulus: rst_n=0 for 1 cycle during ACCESS.
  - Required: next cycle IDLE, bus_req=0, cpu_busy=0, no cpu_ack; a subsequent request completes normally.

Source files
------------

// File: rtl/bus_master_if_if.sv
// rtl/bus_master_if_if.sv - CPU-side and system-bus signal bundle for bus_master_if
interface bus_master_if_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cpu_req;
  logic            cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic [DW/8-1:0] cpu_be;
  logic            cpu_busy;
  logic            cpu_ack;
  logic [DW-1:0]   cpu_rdata;
  logic            cpu_err;
  logic            bus_req;
  logic            bus_grnt;
  logic            bus_as;
  logic [AW-1:0]   bus_addr;
  logic            bus_we;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_be;
  logic [DW-1:0]   bus_rdata;
  logic            bus_rdy;
  logic            bus_err;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_busy, cpu_ack, cpu_rdata, cpu_err,
    output bus_req, bus_as, bus_addr, bus_we, bus_wdata, bus_be,
    input  bus_grnt, bus_rdata, bus_rdy, bus_err
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_busy, cpu_ack, cpu_rdata, cpu_err,
    input  bus_req, bus_as, bus_addr, bus_we, bus_wdata, bus_be,
    output bus_grnt, bus_rdata, bus_rdy, bus_err
  );
endinterface

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - single-beat bus master: arbitrate, access with retry/timeout, acknowledge CPU
module bus_master_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input logic              clk,
  input logic              rst_n,
  bus_master_if_if.master  bif
);
  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_ACCESS, ST_RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t          r_state, w_state_nxt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_be;
  logic [15:0]     r_timer, w_timer_nxt;
  logic [DW-1:0]   r_rdata, w_rdata_nxt;
  logic            r_err, w_err_nxt;
  logic            w_latch;
  logic            w_as;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_timer <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      if (w_latch) begin
        r_we    <= bif.cpu_we;
        r_addr  <= bif.cpu_addr;
        r_wdata <= bif.cpu_wdata;
        r_be    <= bif.cpu_be;
      end
    end
  end

  // Grant loss outranks any slave response seen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bif.cpu_req) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_ARB;
        end
      end
      ST_ARB: begin
        w_timer_nxt = '0;
        if (bif.bus_grnt) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!bif.bus_grnt) begin
          w_state_nxt = ST_ARB;
          w_timer_nxt = '0;
        end else if (bif.bus_err) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end else if (bif.bus_rdy) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = 1'b0;
          w_rdata_nxt = r_we ? '0 : bif.bus_rdata;
        end else if (r_timer == TMO_LAST) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_as          = (r_state == ST_ACCESS) && bif.bus_grnt;
  assign bif.bus_as    = w_as;
  assign bif.bus_addr  = w_as ? r_addr  : '0;
  assign bif.bus_we    = w_as ? r_we    : 1'b0;
  assign bif.bus_wdata = w_as ? r_wdata : '0;
  assign bif.bus_be    = w_as ? r_be    : '0;
  assign bif.bus_req   = (r_state == ST_ARB) || (r_state == ST_ACCESS);
  assign bif.cpu_busy  = (r_state != ST_IDLE);
  assign bif.cpu_ack   = (r_state == ST_RESP);
  assign bif.cpu_rdata = r_rdata;
  assign bif.cpu_err   = r_err;
endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - directed bench with transaction-level model for bus_master_if
module tb_bus_master_if;
  localparam int TMO = 8;

  logic clk;
  logic rst_n;
  int   n_err = 0;
  int   n_chk = 0;
  bit   chk_en = 0;

  bus_master_if_if #(.AW(32), .DW(32)) bif ();

  bus_master_if #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding access, whether it currently holds an attempt,
  // how many attempt cycles have gone by, and a pending acknowledge.
  bit          m_active, m_attempt, m_ack, m_err;
  int          m_cycles;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;
  bit          m_we;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_attempt = 0; m_ack = 0; m_err = 0; m_cycles = 0;
      m_rdata = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_we = 0;
    end else if (m_ack) begin
      m_ack = 0; m_active = 0;
    end else if (!m_active) begin
      if (bif.cpu_req) begin
        m_active = 1; m_attempt = 0;
        m_we = bif.cpu_we; m_addr = bif.cpu_addr; m_wdata = bif.cpu_wdata; m_be = bif.cpu_be;
      end
    end else if (!m_attempt) begin
      if (bif.bus_grnt) begin m_attempt = 1; m_cycles = 0; end
    end else if (!bif.bus_grnt) begin
      m_attempt = 0;
    end else if (bif.bus_err || bif.bus_rdy || m_cycles + 1 == TMO) begin
      m_attempt = 0; m_ack = 1;
      m_err   = bif.bus_err || !bif.bus_rdy;
      m_rdata = (m_err || m_we) ? 32'h0 : bif.bus_rdata;
    end else begin
      m_cycles++;
    end
  end

  int          mon_acks, mon_as;
  logic [31:0] as_addr, as_wdata;
  logic [3:0]  as_be;
  bit          as_we, as_unstable;

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_as;
      e_as = m_attempt && bif.bus_grnt;
      chk("cpu_busy",  bif.cpu_busy,  m_active);
      chk("cpu_ack",   bif.cpu_ack,   m_ack);
      chk("bus_req",   bif.bus_req,   m_active && !m_ack);
      chk("bus_as",    bif.bus_as,    e_as);
      chk("bus_addr",  bif.bus_addr,  e_as ? m_addr : 32'h0);
      chk("bus_we",    bif.bus_we,    e_as ? m_we : 1'b0);
      chk("bus_wdata", bif.bus_wdata, e_as ? m_wdata : 32'h0);
      chk("bus_be",    bif.bus_be,    e_as ? m_be : 4'h0);
      chk("cpu_rdata", bif.cpu_rdata, m_rdata);
      chk("cpu_err",   bif.cpu_err,   m_err);
      if (bif.cpu_ack) mon_acks++;
      if (bif.bus_as) begin
        if (mon_as > 0 && (bif.bus_addr !== as_addr || bif.bus_wdata !== as_wdata ||
                           bif.bus_be !== as_be || bif.bus_we !== as_we))
          as_unstable = 1;
        as_addr = bif.bus_addr; as_wdata = bif.bus_wdata; as_be = bif.bus_be; as_we = bif.bus_we;
        mon_as++;
      end
    end
  end

  function automatic bit vb(input logic [63:0] v, input int i);
    logic [63:0] t;
    t = v;
    return t[(i > 63) ? 63 : i];
  endfunction

  // Vectors: bit k of g/r/e is the slave-side value in cycle k, cycle 0 being the request cycle.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] rdata,
                           input logic [63:0] g, input logic [63:0] r, input logic [63:0] e,
                           output int lat);
    mon_acks = 0; mon_as = 0; as_unstable = 0;
    lat = -1;
    bif.cpu_req = 1; bif.cpu_we = we; bif.cpu_addr = addr; bif.cpu_wdata = wdata; bif.cpu_be = be;
    bif.bus_rdata = rdata;
    bif.bus_grnt = vb(g, 0); bif.bus_rdy = vb(r, 0); bif.bus_err = vb(e, 0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bif.cpu_ack) begin lat = k; break; end
      @(posedge clk); #1;
      bif.cpu_req = 0;
      bif.bus_grnt = vb(g, k + 1); bif.bus_rdy = vb(r, k + 1); bif.bus_err = vb(e, k + 1);
    end
    @(posedge clk); #1;
    bif.bus_rdy = 0; bif.bus_err = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 0;
    bif.cpu_req = 0; bif.cpu_we = 0; bif.cpu_addr = 0; bif.cpu_wdata = 0; bif.cpu_be = 0;
    bif.bus_grnt = 0; bif.bus_rdata = 0; bif.bus_rdy = 0; bif.bus_err = 0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy", bif.cpu_busy, 1'b0);
    chk("rst_ack", bif.cpu_ack, 1'b0);
    chk("rst_bus_req", bif.bus_req, 1'b0);
    chk("rst_rdata", bif.cpu_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Zero-wait read
    do_access(0, 32'h1000_0040, 32'h0, 4'hF, 32'hDEAD_BEEF, ~64'h0, ~64'h0, 64'h0, lat);
    chk("t1_lat", lat, 3);
    chk("t1_as_cycles", mon_as, 1);
    chk("t1_as_addr", as_addr, 32'h1000_0040);
    chk("t1_as_we", as_we, 1'b0);
    chk("t1_rdata", bif.cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_err", bif.cpu_err, 1'b0);
    chk("t1_busy_after", bif.cpu_busy, 1'b0);

    // Write, rdy in the 4th access cycle
    do_access(1, 32'h2000_0008, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF,
              ~64'h0, 64'hFFFF_FFFF_FFFF_FFE0, 64'h0, lat);
    chk("t2_lat", lat, 6);
    chk("t2_as_cycles", mon_as, 4);
    chk("t2_unstable", as_unstable, 1'b0);
    chk("t2_wdata", as_wdata, 32'h1234_5678);
    chk("t2_be", as_be, 4'b0011);
    chk("t2_we", as_we, 1'b1);
    chk("t2_acks", mon_acks, 1);
    chk("t2_rdata", bif.cpu_rdata, 32'h0);

    // Grant drops in 2nd access cycle while rdy is high
    do_access(0, 32'h3000_0010, 32'h0, 4'hF, 32'h0A0B_0C0D,
              ~64'h8, 64'hFFFF_FFFF_FFFF_FFE8, 64'h0, lat);
    chk("t4_lat", lat, 6);
    chk("t4_as_cycles", mon_as, 2);
    chk("t4_acks", mon_acks, 1);
    chk("t4_rdata", bif.cpu_rdata, 32'h0A0B_0C0D);

    // Timeout: slave silent
    do_access(0, 32'h4000_0000, 32'h0, 4'hF, 32'h1111_2222, ~64'h0, 64'h0, 64'h0, lat);
    chk("t5_lat", lat, 10);
    chk("t5_as_cycles", mon_as, TMO);
    chk("t5_err", bif.cpu_err, 1'b1);
    chk("t5_rdata", bif.cpu_rdata, 32'h0);

    // Error together with rdy
    do_access(0, 32'h5000_0004, 32'h0, 4'hF, 32'hCAFE_F00D, ~64'h0, ~64'h0, ~64'h0, lat);
    chk("t6_lat", lat, 3);
    chk("t6_err", bif.cpu_err, 1'b1);
    chk("t6_rdata", bif.cpu_rdata, 32'h0);

    // Late grant: low for 5 cycles after the request
    bif.bus_grnt = 0;
    do_access(0, 32'h6000_0020, 32'h0, 4'hF, 32'h55AA_55AA,
              64'hFFFF_FFFF_FFFF_FFC0, ~64'h0, 64'h0, lat);
    chk("t3_lat", lat, 8);
    chk("t3_as_cycles", mon_as, 1);
    chk("t3_rdata", bif.cpu_rdata, 32'h55AA_55AA);

    // Reset during ACCESS
    mon_acks = 0;
    bif.bus_grnt = 1; bif.bus_rdy = 0; bif.bus_err = 0;
    bif.cpu_req = 1; bif.cpu_we = 0; bif.cpu_addr = 32'h7000_0000;
    @(posedge clk); #1; bif.cpu_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t7_as_before", bif.bus_as, 1'b1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("t7_busy", bif.cpu_busy, 1'b0);
    chk("t7_bus_req", bif.bus_req, 1'b0);
    chk("t7_ack", bif.cpu_ack, 1'b0);
    chk("t7_rdata", bif.cpu_rdata, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("t7_no_ack", mon_acks, 0);

    // Normal read after reset
    do_access(0, 32'h8000_0100, 32'h0, 4'hF, 32'h0BAD_F00D, ~64'h0, ~64'h0, 64'h0, lat);
    chk("t8_lat", lat, 3);
    chk("t8_rdata", bif.cpu_rdata, 32'h0BAD_F00D);
    chk("t8_err", bif.cpu_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
